gpio_seq_ctrl: RTL and testbench
================================

# gpio_seq_ctrl

Bus-master controller that configures and sequences the 8-bit GPIO peripheral through its register port (cs/wr/addr/wdata/rdata). On start it writes a fixed direction mask to MODER. It then steps a programmable pattern table into ODR at a programmable interval. Between steps it polls IDR and pauses while any masked input is high. It sits beside the CPU on the peripheral side, owns the GPIO register port while busy, and is the standard way to run LED/strobe sequences without CPU involvement.

## Interface
- DEPTH, 8: pattern table entries; power of two, 2..16
- PERIOD_W, 24: width of the step interval counter
- DIR_MASK, 32'h0000_00FF: value written to MODER at sequence start; 1 = output
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  pulse; begin sequence when idle
- stop  in  1  pulse; end sequence, clear ODR
- period  in  PERIOD_W  WAIT length in cycles; 0 is treated as 1
- last_idx  in  $clog2(DEPTH)  final table index before wrap
- pause_mask  in  8  IDR bits that hold the sequence while high
- pat_we  in  1  pattern table write strobe
- pat_addr  in  $clog2(DEPTH)  pattern table write index
- pat_wdata  in  8  pattern table write data
- bus_cs  out  1  GPIO chip select
- bus_wr  out  1  GPIO write enable
- bus_addr  out  32  GPIO register address: MODER 0x0, IDR 0x4, ODR 0x8
- bus_wdata  out  32  GPIO write data
- bus_rdata  in  32  GPIO read data; combinational from bus_addr
- busy  out  1  high in every state except IDLE
- paused  out  1  high while held by pause_mask
- step_idx  out  $clog2(DEPTH)  index of the next pattern to write

## Operation
- Reset values:
  - All outputs are 0.
  - The state is IDLE.
  - idx = 0.
  - The pattern table is all 0.
- States: IDLE, CFG, WR_ODR, WAIT, POLL, CLR.
- IDLE:
  - Bus idle (cs=0, wr=0, addr=0, wdata=0).
  - start=1 and stop=0 → CFG, idx ← 0.
- CFG: cs=1, wr=1, addr=0x0, wdata=DIR_MASK. → WR_ODR.
- WR_ODR:
  - cs=1, wr=1, addr=0x8, wdata={24'b0, pat[idx]}.
  - Load cnt ← max(period,1)−1.
  - → WAIT.
- WAIT: bus idle. Stay while cnt≠0, decrementing each cycle; at cnt=0 → POLL.
- POLL:
  - cs=1, wr=0, addr=0x4; sample bus_rdata[7:0] in the same cycle.
  - If (bus_rdata[7:0] & pause_mask) ≠ 0: paused=1, stay in POLL and re-read every cycle.
  - Otherwise: paused=0; idx ← (idx==last_idx) ? 0 : idx+1; → WR_ODR.
- CLR: cs=1, wr=1, addr=0x8, wdata=0. → IDLE.
- stop=1 in any state except IDLE and CLR → CLR next cycle. It overrides every other transition, including in the same cycle as a pause or a wrap.
- start while busy is ignored. start and stop together in IDLE: stop wins, stay IDLE.
- The table can be written at any time. The new value is used the next time that index reaches WR_ODR. A write to the current index in the same cycle as WR_ODR drives the old value.
- last_idx ≥ DEPTH−1 is clamped to DEPTH−1. last_idx is sampled on every wrap decision.
- period and pause_mask are sampled live. period is loaded only in WR_ODR.

## Timing
- Bus outputs are decoded from the state register only. No combinational path runs from start, stop, or pat_* to the bus.
- bus_rdata feeds next-state logic only.
- Start latency:
  - start sampled at edge N.
  - CFG write is driven in cycle N+1.
  - First ODR write is driven in cycle N+2.
- Steady-state step interval = max(period,1) + 2 cycles (WR_ODR + WAIT + POLL).
- Stop latency: CLR is driven in the cycle after stop is sampled. busy=0 one cycle later.
- Every write is a single cycle; the GPIO commits it at the following edge. No wait states.
- step_idx updates at the POLL→WR_ODR edge.
- An asynchronous reset mid-sequence returns to IDLE immediately, bus idle. No CLR write is issued; the GPIO shares the same reset.

## Structure
- Shared package gpio_map_pkg holds:
  - the GPIO register offsets (MODER 0x0, IDR 0x4, ODR 0x8)
  - the state enum for this block.
- Sub-module gpio_seq_pattern_ram holds the table: DEPTH×8, synchronous write, asynchronous read, cleared on reset.
- FSM, interval counter and index logic live in the top module.

## Test plan
- Run with period=3, last_idx=3, pat={0x01,0x02,0x04,0x08}:
  - CFG writes 0xFF to 0x0.
  - ODR writes occur every 5 cycles: 01, 02, 04, 08, 01.
  - step_idx wraps 3→0.
- Pause: pause_mask=0x80 with bus_rdata=0x80 at POLL.
  - paused=1; cs=1, wr=0, addr=4 held.
  - No ODR write until rdata=0x00; the next WR_ODR occurs one cycle later.
- stop during WAIT: CLR writes 0 to 0x8 the next cycle, then IDLE with busy=0.
- stop during pause: CLR follows immediately and paused clears.
- Boundaries:
  - period=0 behaves as period=1 (interval 3).
  - start+stop together in IDLE → no bus activity.
  - start while busy → no restart of idx.
- Table rewrite during a run: pat[2]=0x55 written while idx=0 → third ODR write is 0x55.
- Async reset asserted mid-WAIT: all outputs 0 within the same cycle. The table reads 0 after release.

Source files
------------

// File: rtl/gpio_map_pkg.sv
// GPIO peripheral register map and the sequencer state encoding shared by
// the GPIO sequencing blocks.
package gpio_map_pkg;

  localparam logic [31:0] GPIO_MODER = 32'h0000_0000;
  localparam logic [31:0] GPIO_IDR   = 32'h0000_0004;
  localparam logic [31:0] GPIO_ODR   = 32'h0000_0008;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_WR_ODR,
    ST_WAIT,
    ST_POLL,
    ST_CLR
  } seq_state_e;

endpackage

// File: rtl/gpio_seq_pattern_ram.sv
// Pattern table for the GPIO sequencer: DEPTH x 8, synchronous write,
// asynchronous read, cleared by reset.
module gpio_seq_pattern_ram #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [7:0]               i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [7:0]               o_rdata
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read sees the pre-write value in the cycle of a same-index write.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/gpio_seq_ctrl.sv
// GPIO sequencer: configures MODER, then steps a pattern table into ODR at a
// programmable interval, holding while masked IDR inputs are high.
module gpio_seq_ctrl
  import gpio_map_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter int          PERIOD_W = 24,
  parameter logic [31:0] DIR_MASK = 32'h0000_00FF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic [PERIOD_W-1:0]      i_period,
  input  logic [$clog2(DEPTH)-1:0] i_last_idx,
  input  logic [7:0]               i_pause_mask,
  input  logic                     i_pat_we,
  input  logic [$clog2(DEPTH)-1:0] i_pat_addr,
  input  logic [7:0]               i_pat_wdata,
  output logic                     o_bus_cs,
  output logic                     o_bus_wr,
  output logic [31:0]              o_bus_addr,
  output logic [31:0]              o_bus_wdata,
  input  logic [31:0]              i_bus_rdata,
  output logic                     o_busy,
  output logic                     o_paused,
  output logic [$clog2(DEPTH)-1:0] o_step_idx
);

  localparam int             IW      = $clog2(DEPTH);
  localparam logic [IW-1:0]  IDX_MAX = IW'(DEPTH - 1);

  seq_state_e          r_state;
  seq_state_e          w_state_nxt;
  logic [IW-1:0]       r_idx;
  logic [PERIOD_W-1:0] r_cnt;
  logic                r_paused;
  logic [7:0]          w_pat;
  logic                w_hold;
  logic                w_wrap;
  logic                w_unused_rdata;

  function automatic logic [PERIOD_W-1:0] f_interval_load(input logic [PERIOD_W-1:0] p);
    return (p == '0) ? '0 : p - PERIOD_W'(1);
  endfunction

  gpio_seq_pattern_ram #(
    .DEPTH (DEPTH)
  ) u_pat_ram (
    .clk     (clk),
    .reset   (reset),
    .i_we    (i_pat_we),
    .i_waddr (i_pat_addr),
    .i_wdata (i_pat_wdata),
    .i_raddr (r_idx),
    .o_rdata (w_pat)
  );

  assign w_hold         = (i_bus_rdata[7:0] & i_pause_mask) != 8'h00;
  // Out-of-range last_idx is clamped by also wrapping at the top entry.
  assign w_wrap         = (r_idx == i_last_idx) || (r_idx == IDX_MAX);
  assign w_unused_rdata = ^i_bus_rdata[31:8];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (i_start && !i_stop) w_state_nxt = ST_CFG;
      ST_CFG:    w_state_nxt = ST_WR_ODR;
      ST_WR_ODR: w_state_nxt = ST_WAIT;
      ST_WAIT:   if (r_cnt == '0) w_state_nxt = ST_POLL;
      ST_POLL:   if (!w_hold) w_state_nxt = ST_WR_ODR;
      ST_CLR:    w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (i_stop && (r_state != ST_IDLE) && (r_state != ST_CLR)) begin
      w_state_nxt = ST_CLR;
    end
  end

  always_comb begin
    o_bus_cs    = 1'b0;
    o_bus_wr    = 1'b0;
    o_bus_addr  = '0;
    o_bus_wdata = '0;
    case (r_state)
      ST_CFG: begin
        o_bus_cs    = 1'b1;
        o_bus_wr    = 1'b1;
        o_bus_addr  = GPIO_MODER;
        o_bus_wdata = DIR_MASK;
      end
      ST_WR_ODR: begin
        o_bus_cs    = 1'b1;
        o_bus_wr    = 1'b1;
        o_bus_addr  = GPIO_ODR;
        o_bus_wdata = {24'h0, w_pat};
      end
      ST_POLL: begin
        o_bus_cs    = 1'b1;
        o_bus_addr  = GPIO_IDR;
      end
      ST_CLR: begin
        o_bus_cs    = 1'b1;
        o_bus_wr    = 1'b1;
        o_bus_addr  = GPIO_ODR;
      end
      default: ;
    endcase
  end

  assign o_busy     = (r_state != ST_IDLE);
  assign o_paused   = r_paused;
  assign o_step_idx = r_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_paused <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_paused <= (r_state == ST_POLL) && (w_state_nxt == ST_POLL);
      if ((r_state == ST_IDLE) && (w_state_nxt == ST_CFG)) begin
        r_idx <= '0;
      end else if ((r_state == ST_POLL) && (w_state_nxt == ST_WR_ODR)) begin
        r_idx <= w_wrap ? '0 : r_idx + IW'(1);
      end
      if (r_state == ST_WR_ODR) begin
        r_cnt <= f_interval_load(i_period);
      end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - PERIOD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_gpio_seq_ctrl.sv
// Self-checking bench for gpio_seq_ctrl: cycle-exact vector table, hand
// sequences for stop/pause/reset corners, and randomized runs vs a write-list model.
module tb_gpio_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop;
  logic [23:0] period;
  logic [2:0]  last_idx;
  logic [7:0]  pause_mask;
  logic        pat_we;
  logic [2:0]  pat_addr;
  logic [7:0]  pat_wdata;
  logic        bus_cs, bus_wr;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        busy, paused;
  logic [2:0]  step_idx;

  logic [7:0]  idr;
  logic [7:0]  odr_m;
  logic [31:0] moder_m;
  logic [7:0]  pat_m [8];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
    int          idx;
  } wr_t;
  wr_t mon_q[$];
  wr_t exp_q[$];

  typedef struct {
    logic        st, sp;
    logic [7:0]  idr;
    logic        cs, wr;
    logic [31:0] addr, wdata;
    logic        busy, paused;
    logic [2:0]  idx;
  } vec_t;
  vec_t vecs[15];

  gpio_seq_ctrl #(.DEPTH(8), .PERIOD_W(24), .DIR_MASK(32'h0000_00FF)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (start),
    .i_stop       (stop),
    .i_period     (period),
    .i_last_idx   (last_idx),
    .i_pause_mask (pause_mask),
    .i_pat_we     (pat_we),
    .i_pat_addr   (pat_addr),
    .i_pat_wdata  (pat_wdata),
    .o_bus_cs     (bus_cs),
    .o_bus_wr     (bus_wr),
    .o_bus_addr   (bus_addr),
    .o_bus_wdata  (bus_wdata),
    .i_bus_rdata  (bus_rdata),
    .o_busy       (busy),
    .o_paused     (paused),
    .o_step_idx   (step_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Minimal GPIO peripheral: register writes commit at the edge, reads are combinational.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      odr_m   <= 8'h00;
      moder_m <= 32'h0;
    end else if (bus_cs && bus_wr) begin
      if (bus_addr == 32'h8) odr_m <= bus_wdata[7:0];
      if (bus_addr == 32'h0) moder_m <= bus_wdata;
    end
  end

  always_comb begin
    bus_rdata = 32'h0;
    if (bus_addr == 32'h4) bus_rdata = {24'h0, idr};
    else if (bus_addr == 32'h8) bus_rdata = {24'h0, odr_m};
    else if (bus_addr == 32'h0) bus_rdata = moder_m;
  end

  always @(negedge clk) begin
    if (bus_cs && bus_wr) mon_q.push_back('{cyc, bus_addr, bus_wdata, int'(step_idx)});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, time %0t", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string name);
    chk(name, 128'({bus_cs, bus_wr, bus_addr, bus_wdata, busy, paused, step_idx}), 128'(0));
  endtask

  task automatic write_pat(input int a, input logic [7:0] d);
    @(negedge clk);
    pat_we = 1'b1; pat_addr = 3'(a); pat_wdata = d;
    pat_m[a] = d;
    @(negedge clk);
    pat_we = 1'b0;
  endtask

  function automatic vec_t mk(logic st, logic sp, logic [7:0] i, logic cs, logic wr,
                              logic [31:0] a, logic [31:0] d, logic b, logic p, logic [2:0] ix);
    vec_t v;
    v.st = st; v.sp = sp; v.idr = i; v.cs = cs; v.wr = wr;
    v.addr = a; v.wdata = d; v.busy = b; v.paused = p; v.idx = ix;
    return v;
  endfunction

  // Runs one sequence for len cycles with random IDR, then stops; the expected
  // bus write list is derived from the step-timing rules and compared in full.
  task automatic run_round(input int p, input int last, input logic [7:0] mask, input int len,
                           input int pct, input int restart_at, input int rewrite_at);
    int t0, ts, t, poll, i, li;
    logic [7:0] idr_log [0:255];
    period = 24'(p); last_idx = 3'(last); pause_mask = mask;
    @(negedge clk);
    mon_q.delete(); exp_q.delete();
    start = 1'b1; idr = 8'h00; t0 = cyc;
    for (int r = 1; r <= len; r++) begin
      @(negedge clk);
      start  = (r == restart_at);
      pat_we = 1'b0;
      if (r == rewrite_at) begin
        pat_we = 1'b1; pat_addr = 3'd2; pat_wdata = 8'h55; pat_m[2] = 8'h55;
      end
      idr = ($urandom_range(0, 99) < pct) ? (8'($urandom) | mask) : (8'($urandom) & ~mask);
      idr_log[r] = idr;
      if (r == len) stop = 1'b1;
    end
    ts = t0 + len;
    @(negedge clk);
    stop = 1'b0; start = 1'b0; pat_we = 1'b0; idr = 8'h00;
    @(negedge clk);
    chk($sformatf("round_end_busy_paused_t0_%0d", t0), 128'({busy, paused}), 128'(0));

    exp_q.push_back('{t0 + 1, 32'h0, 32'hFF, 0});
    t = t0 + 2; i = 0; li = 0;
    while (t <= ts) begin
      exp_q.push_back('{t, 32'h8, {24'h0, pat_m[i]}, i});
      li = i;
      poll = t + ((p == 0) ? 1 : p) + 1;
      while (poll <= ts && (idr_log[poll - t0] & mask) != 8'h00) poll++;
      t = poll + 1;
      i = (i >= last) ? 0 : i + 1;
    end
    exp_q.push_back('{ts + 1, 32'h8, 32'h0, li});

    chk($sformatf("write_count_t0_%0d", t0), 128'(mon_q.size()), 128'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < mon_q.size(); k++) begin
      chk($sformatf("write%0d_cyc_addr_data_idx_t0_%0d", k, t0),
          {32'(mon_q[k].cyc), mon_q[k].addr, mon_q[k].data, 32'(mon_q[k].idx)},
          {32'(exp_q[k].cyc), exp_q[k].addr, exp_q[k].data, 32'(exp_q[k].idx)});
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; period = 24'd1; last_idx = 3'd1;
    pause_mask = 8'h80; pat_we = 1'b0; pat_addr = 3'd0; pat_wdata = 8'h00; idr = 8'h00;
    for (int a = 0; a < 8; a++) pat_m[a] = 8'h00;

    vecs[0]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h00, 1'b0, 1'b0, 3'd0);
    vecs[1]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0, 32'hFF, 1'b1, 1'b0, 3'd0);
    vecs[2]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h8, 32'h11, 1'b1, 1'b0, 3'd0);
    vecs[3]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h00, 1'b1, 1'b0, 3'd0);
    vecs[4]  = mk(1'b0, 1'b0, 8'h7F, 1'b1, 1'b0, 32'h4, 32'h00, 1'b1, 1'b0, 3'd0);
    vecs[5]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h8, 32'h22, 1'b1, 1'b0, 3'd1);
    vecs[6]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h00, 1'b1, 1'b0, 3'd1);
    vecs[7]  = mk(1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 32'h4, 32'h00, 1'b1, 1'b0, 3'd1);
    vecs[8]  = mk(1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 32'h4, 32'h00, 1'b1, 1'b1, 3'd1);
    vecs[9]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h4, 32'h00, 1'b1, 1'b1, 3'd1);
    vecs[10] = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 32'h8, 32'h11, 1'b1, 1'b0, 3'd0);
    vecs[11] = mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 32'h0, 32'h00, 1'b1, 1'b0, 3'd0);
    vecs[12] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h8, 32'h00, 1'b1, 1'b0, 3'd0);
    vecs[13] = mk(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 32'h0, 32'h00, 1'b0, 1'b0, 3'd0);
    vecs[14] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h00, 1'b0, 1'b0, 3'd0);

    repeat (2) @(negedge clk);
    chk_idle("reset_held_outputs");
    reset = 1'b0;
    @(negedge clk);
    chk_idle("reset_released_outputs");

    write_pat(0, 8'h11);
    write_pat(1, 8'h22);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      start = vecs[k].st; stop = vecs[k].sp; idr = vecs[k].idr;
      chk($sformatf("vec%0d", k),
          128'({bus_cs, bus_wr, bus_addr, bus_wdata, busy, paused, step_idx}),
          128'({vecs[k].cs, vecs[k].wr, vecs[k].addr, vecs[k].wdata,
                vecs[k].busy, vecs[k].paused, vecs[k].idx}));
    end
    start = 1'b0; stop = 1'b0; idr = 8'h00;

    // Stop while in WAIT.
    write_pat(0, 8'h01); write_pat(1, 8'h02); write_pat(2, 8'h04); write_pat(3, 8'h08);
    period = 24'd3; last_idx = 3'd3; pause_mask = 8'h00;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("stop_wait_in_wait", 128'({bus_cs, busy}), 128'(2'b01));
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("stop_wait_clr", 128'({bus_cs, bus_wr, bus_addr, bus_wdata}), 128'({2'b11, 32'h8, 32'h0}));
    @(negedge clk);
    chk_idle("stop_wait_idle");

    // Stop while held in POLL.
    period = 24'd1; pause_mask = 8'h80; idr = 8'h80;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pause_held", 128'({bus_cs, bus_wr, bus_addr, paused}), 128'({2'b10, 32'h4, 1'b1}));
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("pause_stop_clr", 128'({bus_cs, bus_wr, bus_addr, bus_wdata, paused}),
        128'({2'b11, 32'h8, 32'h0, 1'b0}));
    @(negedge clk);
    chk("pause_stop_idle", 128'({busy, paused}), 128'(0));
    idr = 8'h00;

    // Plain run, then a run with a table rewrite and an ignored restart.
    run_round(3, 3, 8'h00, 28, 0, 0, 0);
    run_round(3, 3, 8'h00, 22, 0, 9, 1);
    chk("rewrite_third_odr", (mon_q.size() > 3) ? 128'(mon_q[3].data) : 128'hx, 128'(32'h55));
    run_round(0, 2, 8'h00, 15, 0, 0, 0);
    run_round(2, 1, 8'h81, 30, 50, 0, 0);

    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < 8; a++) write_pat(a, 8'($urandom));
      run_round($urandom_range(0, 4), $urandom_range(0, 7), 8'($urandom_range(1, 255)),
                $urandom_range(30, 60), 30, $urandom_range(3, 20), 0);
    end

    // Asynchronous reset in the middle of WAIT.
    write_pat(0, 8'hA5);
    period = 24'd3; last_idx = 3'd3; pause_mask = 8'h00;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_idle("async_reset_mid_wait");
    @(negedge clk); reset = 1'b0;
    for (int a = 0; a < 8; a++) pat_m[a] = 8'h00;
    period = 24'd1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("post_reset_table_zero", 128'({bus_cs, bus_wr, bus_addr, bus_wdata, step_idx}),
        128'({2'b11, 32'h8, 32'h0, 3'd0}));
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    @(negedge clk);
    chk_idle("post_reset_stopped");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
